uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_buffered.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_115200 = 434;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed from a word FIFO: start, LSB-first data, optional parity, 1-2 stop bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int unsigned BITS_N       = 8,
    parameter int unsigned PARITY_TYPE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BITS_N-1:0]             data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          uart_out,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam parity_e           PARITY    = parity_e'(2'(PARITY_TYPE));

    tx_state_e          state;
    logic [BAUD_W-1:0]  baud;
    logic [3:0]         bit_idx;
    logic [BITS_N-1:0]  shreg;
    logic [BITS_N-1:0]  head;
    logic               par_bit;
    logic               full;
    logic               empty;
    logic               pop;
    logic               baud_end;

    assign ready_out = !rst && !full;
    assign pop       = (state == IDLE) && !empty;
    assign baud_end  = (baud == BAUD_LAST);
    assign busy      = (state != IDLE);
    assign tx_done   = (state == STOP_BIT) && baud_end && (bit_idx == 4'(STOP_BITS - 1));

    sync_fifo #(
        .WIDTH (BITS_N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (valid_in && ready_out),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // uart_out is loaded with the level of the bit being entered, so it stays registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            uart_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shreg    <= head;
                        par_bit  <= (PARITY == ODD) ? ~^head : ^head;
                        baud     <= '0;
                        bit_idx  <= '0;
                        state    <= START_BIT;
                        uart_out <= 1'b0;
                    end
                end
                START_BIT: begin
                    if (baud_end) begin
                        baud     <= '0;
                        bit_idx  <= '0;
                        state    <= DATA_BITS;
                        uart_out <= shreg[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 4'(BITS_N - 1)) begin
                            bit_idx <= '0;
                            if (PARITY == NONE) begin
                                state    <= STOP_BIT;
                                uart_out <= 1'b1;
                            end else begin
                                state    <= PARITY_BIT;
                                uart_out <= par_bit;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            shreg    <= shreg >> 1;
                            uart_out <= shreg[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                PARITY_BIT: begin
                    if (baud_end) begin
                        baud     <= '0;
                        bit_idx  <= '0;
                        state    <= STOP_BIT;
                        uart_out <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 4'(STOP_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
